countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counting timer, the counting-down counterpart to the team's up-counting ripple counter.
- Accepts a start value through a valid/ready load handshake, then decrements once per prescaled tick.
- Emits a one-cycle terminal-count pulse, with optional auto-reload for periodic operation.
- Sits beside the counter library as the general-purpose timeout/period generator.

Parameters:
WIDTH, 4, bit width of load_value, count and the reload register (>=2)
PRESCALE, 1, clk cycles per decrement tick (>=1); 1 = decrement every cycle

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  reset, asynchronous, active-high
load_valid  input  1  start request; load_value valid while high
load_value  input  WIDTH  initial and reload count
load_ready  output  1  high when the timer accepts a load (IDLE only)
auto_reload  input  1  sampled at terminal tick; 1 = restart from the reload register
pause  input  1  freezes prescaler and count while high (RUN only)
abort  input  1  cancels a running count
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN
tc_pulse  output  1  one-cycle pulse on terminal count (registered)

Behaviour:
- Reset, asynchronous and immediate (including mid-count):
  - state=IDLE, count=0, reload_reg=0, prescale counter=0.
  - busy=0, tc_pulse=0, load_ready=1.
- States: IDLE, RUN. busy = (state==RUN). load_ready = (state==IDLE). Moore outputs only.
- Tick: in RUN with pause=0, tick=1 when prescale counter == PRESCALE-1.
  - The prescale counter increments each unpaused RUN cycle and wraps to 0 on tick.
  - It is cleared on load and on leaving RUN.
- IDLE:
  - On load_valid&&load_ready with load_value!=0: count<=load_value, reload_reg<=load_value, prescale counter<=0, state<=RUN.
  - On load_value==0: no state change, count stays 0, tc_pulse=1 on the next cycle (zero-length timeout).
  - abort in IDLE has no effect.
- RUN, priority highest first:
  - abort: state<=IDLE, count<=0, no tc_pulse. Abort wins over a same-cycle tick.
  - pause: count and prescale counter hold. A tick cannot occur.
  - tick with count>1: count<=count-1.
  - tick with count==1: tc_pulse<=1 for exactly one cycle.
    - auto_reload=1: count<=reload_reg, stay RUN.
    - auto_reload=0: count<=0, state<=IDLE.
- load_valid in RUN is ignored (load_ready=0). No request is queued.
- Latency with PRESCALE=1: load handshake at edge k gives count=N after edge k and tc_pulse=1 for the cycle after edge k+N.
  - Generally, tc_pulse follows the load by N*PRESCALE cycles.
- Auto-reload period: N*PRESCALE cycles between tc_pulses, with no dead cycle.
- Arithmetic is unsigned, modulo 2^WIDTH. Decrement never underflows, because count==1 is the terminal condition.
- A load with load_value = 2^WIDTH-1 must work (maximum period).
- tc_pulse is 0 in every cycle not specified above.

Decomposition:
- Shared package counter_pkg:
  - state enum (IDLE, RUN).
  - localparam helpers for prescale counter width, $clog2(PRESCALE) with a minimum of 1.
- One sub-module, timer_prescaler (clk, reset_n, enable, clear -> tick), holding the prescale counter.
  - For PRESCALE=1 it degenerates to tick=enable.
- The top holds the FSM, count and reload_reg.

Test Plan:
- Reset mid-run: load 9, wait 3 cycles, pulse reset_n=1 -> count=0, busy=0, load_ready=1, tc_pulse=0 immediately. No tc_pulse afterwards.
- Basic countdown, PRESCALE=1: load 5 -> count 5,4,3,2,1,0 on consecutive cycles, tc_pulse high exactly 1 cycle, coincident with count==0. busy drops the same cycle; load_ready=1.
- Auto-reload, PRESCALE=1: auto_reload=1, load 3 -> count sequence 3,2,1,3,2,1,... and tc_pulse every 3 cycles. Dropping auto_reload -> next terminal goes to 0/IDLE.
- Prescale and pause, PRESCALE=4: load 2 -> decrement every 4 cycles. Pause for 5 cycles mid-run -> count and prescale frozen, and the tc_pulse time is delayed by exactly 5 cycles.
- Abort and ignored load: load 7, then assert load_valid with 2 during RUN -> ignored. abort at count=4 coinciding with a tick -> count=0, IDLE, no tc_pulse.
- Edge values, WIDTH=4: load 0 -> tc_pulse next cycle, busy stays 0. Load 15 -> tc_pulse after exactly 15 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and sizing helpers for the counter/timer library.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Prescale counter width; a single bit is kept even when PRESCALE is 1.
    function automatic int unsigned ps_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control and status bundle of the countdown timer.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic             auto_reload;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;

    modport master (
        output load_valid, load_value, auto_reload, pause, abort,
        input  load_ready, count, busy, tc_pulse
    );

    modport slave (
        input  load_valid, load_value, auto_reload, pause, abort,
        output load_ready, count, busy, tc_pulse
    );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Divides enabled cycles down to one decrement tick every PRESCALE cycles.
module timer_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int unsigned PS_W = ps_width(PRESCALE);

    logic [PS_W-1:0] cnt_q;

    // With PRESCALE of 1 the counter never leaves 0, so tick follows enable.
    assign tick = enable && (cnt_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + PS_W'(1);
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with terminal-count pulse and optional auto-reload.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input logic              clk,
    input logic              reset_n,
    countdown_timer_if.slave bus
);
    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             busy_q;
    logic             ready_q;

    logic ps_enable;
    logic ps_clear;
    logic ps_tick;
    logic terminal;

    assign ps_enable = (state_q == RUN) && !bus.pause;
    assign terminal  = ps_tick && (count_q == WIDTH'(1));
    // Prescaler restarts from zero whenever the timer is idle or about to leave RUN.
    assign ps_clear  = (state_q == IDLE) || bus.abort || (terminal && !bus.auto_reload);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (ps_enable),
        .clear   (ps_clear),
        .tick    (ps_tick)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        if (bus.load_value != '0) begin
                            count_q  <= bus.load_value;
                            reload_q <= bus.load_value;
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                        end else begin
                            // Zero-length timeout: report expiry without ever running.
                            tc_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        count_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (terminal) begin
                        tc_q <= 1'b1;
                        if (bus.auto_reload) begin
                            count_q <= reload_q;
                        end else begin
                            count_q <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end else if (ps_tick) begin
                        count_q <= count_q - WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign bus.count      = count_q;
    assign bus.busy       = busy_q;
    assign bus.load_ready = ready_q;
    assign bus.tc_pulse   = tc_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer at PRESCALE 1 and PRESCALE 4.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(4)) if1 ();
    countdown_timer_if #(.WIDTH(4)) if4 ();

    countdown_timer #(.WIDTH(4), .PRESCALE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    countdown_timer #(.WIDTH(4), .PRESCALE(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit lv; int val; bit au; bit pa; bit ab;
        int e_count; bit e_busy; bit e_tc;
    } vec_t;

    typedef struct {
        bit run; int n; int el;
    } mdl_t;

    vec_t vq[$];

    function automatic vec_t mk(input bit lv, input int val, input bit au, input bit pa,
                                input bit ab, input int ec, input bit eb, input bit et);
        vec_t v;
        v.lv = lv; v.val = val; v.au = au; v.pa = pa; v.ab = ab;
        v.e_count = ec; v.e_busy = eb; v.e_tc = et;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: time since load measured in unpaused cycles, count derived arithmetically.
    function automatic void mstep(inout mdl_t m, input int p, input bit lv, input int val,
                                  input bit au, input bit pa, input bit ab, output bit tc);
        tc = 1'b0;
        if (!m.run) begin
            if (lv) begin
                if (val == 0) tc = 1'b1;
                else begin m.run = 1'b1; m.n = val; m.el = 0; end
            end
        end else if (ab) begin
            m.run = 1'b0;
        end else if (!pa) begin
            m.el++;
            if (m.el == m.n * p) begin
                tc = 1'b1;
                m.el = 0;
                if (!au) m.run = 1'b0;
            end
        end
    endfunction

    function automatic int mcount(input mdl_t m, input int p);
        return m.run ? m.n - ((m.el / p) % m.n) : 0;
    endfunction

    task automatic drive1(input bit lv, input int val, input bit au, input bit pa, input bit ab);
        if1.load_valid = lv; if1.load_value = 4'(val);
        if1.auto_reload = au; if1.pause = pa; if1.abort = ab;
    endtask

    task automatic drive4(input bit lv, input int val, input bit au, input bit pa, input bit ab);
        if4.load_valid = lv; if4.load_value = 4'(val);
        if4.auto_reload = au; if4.pause = pa; if4.abort = ab;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mdl_t m1, m4;
        bit   t1, t4;
        int   lat;
        bit   lv, au, pa, ab;
        int   val;

        drive1(0, 0, 0, 0, 0);
        drive4(0, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst_count1", int'(if1.count), 0);
        chk("rst_busy1", int'(if1.busy), 0);
        chk("rst_ready1", int'(if1.load_ready), 1);
        chk("rst_tc1", int'(if1.tc_pulse), 0);
        chk("rst_count4", int'(if4.count), 0);
        chk("rst_ready4", int'(if4.load_ready), 1);
        reset_n = 1'b0;
        step();

        // Directed vectors on the PRESCALE=1 instance.
        vq.push_back(mk(1, 5, 0, 0, 0, 5, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
        vq.push_back(mk(1, 2, 0, 0, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 7, 0, 0, 0, 7, 1, 0));
        vq.push_back(mk(1, 2, 0, 0, 0, 6, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, 1, 0, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 3, 1, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 2, 0, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));

        foreach (vq[i]) begin
            drive1(vq[i].lv, vq[i].val, vq[i].au, vq[i].pa, vq[i].ab);
            step();
            chk($sformatf("vec%0d_count", i), int'(if1.count), vq[i].e_count);
            chk($sformatf("vec%0d_busy", i), int'(if1.busy), int'(vq[i].e_busy));
            chk($sformatf("vec%0d_ready", i), int'(if1.load_ready), int'(!vq[i].e_busy));
            chk($sformatf("vec%0d_tc", i), int'(if1.tc_pulse), int'(vq[i].e_tc));
        end
        drive1(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a count.
        drive1(1, 9, 0, 0, 0);
        step();
        drive1(0, 0, 0, 0, 0);
        repeat (3) step();
        chk("midrst_pre_count", int'(if1.count), 6);
        #2 reset_n = 1'b1;
        #1;
        chk("midrst_count", int'(if1.count), 0);
        chk("midrst_busy", int'(if1.busy), 0);
        chk("midrst_ready", int'(if1.load_ready), 1);
        chk("midrst_tc", int'(if1.tc_pulse), 0);
        step();
        reset_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("midrst_no_tc", int'(if1.tc_pulse), 0);
        end

        // Maximum load value gives the full period.
        drive1(1, 15, 0, 0, 0);
        step();
        drive1(0, 0, 0, 0, 0);
        chk("max_count", int'(if1.count), 15);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (if1.tc_pulse) begin lat = i; break; end
        end
        chk("max_latency", lat, 15);

        // Prescaled countdown without pause.
        drive4(1, 2, 0, 0, 0);
        step();
        drive4(0, 0, 0, 0, 0);
        chk("ps_count_load", int'(if4.count), 2);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 3) chk("ps_hold", int'(if4.count), 2);
            if (i == 4) chk("ps_dec", int'(if4.count), 1);
            if (if4.tc_pulse) begin lat = i; break; end
        end
        chk("ps_latency", lat, 8);
        chk("ps_end_busy", int'(if4.busy), 0);

        // Five paused cycles delay the terminal count by exactly five.
        drive4(1, 2, 0, 0, 0);
        step();
        drive4(0, 0, 0, 0, 0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if4.pause = (i >= 3 && i <= 7);
            step();
            if (i == 8) chk("pause_frozen", int'(if4.count), 2);
            if (i == 9) chk("pause_dec", int'(if4.count), 1);
            if (if4.tc_pulse) begin lat = i; break; end
        end
        if4.pause = 1'b0;
        chk("pause_latency", lat, 13);

        // Randomised traffic against the reference model on both instances.
        drive1(0, 0, 0, 0, 1);
        drive4(0, 0, 0, 0, 1);
        step();
        m1 = '{run: 1'b0, n: 0, el: 0};
        m4 = '{run: 1'b0, n: 0, el: 0};
        for (int c = 0; c < 3000; c++) begin
            lv = ($urandom_range(0, 3) == 0); val = $urandom_range(0, 15);
            au = $urandom_range(0, 1) == 1;   pa = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 40) == 0);
            drive1(lv, val, au, pa, ab);
            mstep(m1, 1, lv, val, au, pa, ab, t1);
            lv = ($urandom_range(0, 3) == 0); val = $urandom_range(0, 15);
            au = $urandom_range(0, 1) == 1;   pa = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 60) == 0);
            drive4(lv, val, au, pa, ab);
            mstep(m4, 4, lv, val, au, pa, ab, t4);
            step();
            chk("rnd1_count", int'(if1.count), mcount(m1, 1));
            chk("rnd1_busy", int'(if1.busy), int'(m1.run));
            chk("rnd1_ready", int'(if1.load_ready), int'(!m1.run));
            chk("rnd1_tc", int'(if1.tc_pulse), int'(t1));
            chk("rnd4_count", int'(if4.count), mcount(m4, 4));
            chk("rnd4_busy", int'(if4.busy), int'(m4.run));
            chk("rnd4_ready", int'(if4.load_ready), int'(!m4.run));
            chk("rnd4_tc", int'(if4.tc_pulse), int'(t4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
